// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types and constants for the CIM column input-activation sequencer
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } cim_seq_state_t;

    // Column registers ia and the tree sum before accum consumes shift.
    localparam int COL_PIPE_DEPTH = 2;
    localparam int DRAIN_CYCLES   = 3;

    function automatic int sum_width(input int wordlen, input int log2_nrows, input int log2_wordlen);
        return wordlen + log2_nrows + log2_wordlen;
    endfunction

endpackage

// File: rtl/cim_shift_align.sv
// rtl/cim_shift_align.sv - N-deep {valid, shift} delay line; output shift forced to 0 when invalid
module cim_shift_align #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         valid_i,
    input  logic [W-1:0] shift_i,
    output logic [W-1:0] shift_o
);

    logic [N-1:0]        valid_q;
    logic [N-1:0][W-1:0] shift_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            shift_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            shift_q[0] <= shift_i;
            for (int j = 1; j < N; j++) begin
                valid_q[j] <= valid_q[j-1];
                shift_q[j] <= shift_q[j-1];
            end
        end
    end

    assign shift_o = valid_q[N-1] ? shift_q[N-1] : '0;

endmodule

// File: rtl/cim_ia_sequencer.sv
// rtl/cim_ia_sequencer.sv - bit-serial activation driver for one CIM column with baseline-differenced result
module cim_ia_sequencer
    import cim_pkg::*;
#(
    parameter int WORDLEN      = 8,
    parameter int LOG2_WORDLEN = 3,
    parameter int NROWS        = 64,
    parameter int LOG2_NROWS   = 6,
    parameter int IA_BITS      = 8,
    parameter int SUMW         = sum_width(WORDLEN, LOG2_NROWS, LOG2_WORDLEN)
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NROWS-1:0][IA_BITS-1:0]   in_act,
    output logic [NROWS-1:0]                col_ia,
    output logic [WORDLEN-1:0]              col_shift,
    input  logic signed [SUMW-1:0]          col_sum,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [SUMW-1:0]          out_result,
    output logic                            busy
);

    // One spare bit so the counter also covers the drain count when WORDLEN is tiny.
    localparam int             CW         = LOG2_WORDLEN + 1;
    localparam logic [CW-1:0]  LAST_BIT   = CW'(IA_BITS - 1);
    localparam logic [CW-1:0]  LAST_DRAIN = CW'(DRAIN_CYCLES - 1);

    cim_seq_state_t                state_q, state_d;
    logic [NROWS-1:0][IA_BITS-1:0] act_q, act_d;
    logic signed [SUMW-1:0]        base_q, base_d;
    logic signed [SUMW-1:0]        result_q, result_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          streaming;
    logic [WORDLEN-1:0]            shift_in;
    logic [IA_BITS-1:0]            row_bits;

    assign streaming = (state_q == STREAM);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)              state_d = STREAM;
            STREAM:  if (cnt_q == LAST_BIT)     state_d = DRAIN;
            DRAIN:   if (cnt_q == LAST_DRAIN)   state_d = DONE;
            DONE:    if (out_ready)             state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        col_ia    = '0;
        row_bits  = '0;
        if (streaming) begin
            for (int i = 0; i < NROWS; i++) begin
                row_bits  = act_q[i] >> cnt_q;
                col_ia[i] = row_bits[0];
            end
        end
    end

    // Baseline is sampled at accept; the column is quiescent then, so end-minus-base is exact mod 2^SUMW.
    always_comb begin
        act_d    = act_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    act_d  = in_act;
                    base_d = col_sum;
                    cnt_d  = '0;
                end
            end
            STREAM: begin
                cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + CW'(1);
            end
            DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    result_d = col_sum - base_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            act_q    <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            act_q    <= act_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign out_result = result_q;
    assign shift_in   = streaming ? WORDLEN'(cnt_q) : '0;

    cim_shift_align #(
        .N (COL_PIPE_DEPTH),
        .W (WORDLEN)
    ) u_shift_align (
        .clock   (clock),
        .resetn  (resetn),
        .valid_i (streaming),
        .shift_i (shift_in),
        .shift_o (col_shift)
    );

endmodule

// File: tb/tb_cim_ia_sequencer.sv
// tb/tb_cim_ia_sequencer.sv - directed bench driving the sequencer into a behavioural CIM column
module tb_cim_ia_sequencer;

    localparam int WORDLEN      = 8;
    localparam int LOG2_WORDLEN = 3;
    localparam int NROWS        = 64;
    localparam int LOG2_NROWS   = 6;
    localparam int IA_BITS      = 8;
    localparam int SUMW         = 17;
    localparam int TREEW        = WORDLEN + LOG2_NROWS;

    logic                          clock = 1'b0;
    logic                          resetn;
    logic                          in_valid;
    logic                          in_ready;
    logic [NROWS-1:0][IA_BITS-1:0] in_act;
    logic [NROWS-1:0]              col_ia;
    logic [WORDLEN-1:0]            col_shift;
    logic signed [SUMW-1:0]        col_sum;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [SUMW-1:0]        out_result;
    logic                          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cim_ia_sequencer #(
        .WORDLEN      (WORDLEN),
        .LOG2_WORDLEN (LOG2_WORDLEN),
        .NROWS        (NROWS),
        .LOG2_NROWS   (LOG2_NROWS),
        .IA_BITS      (IA_BITS),
        .SUMW         (SUMW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .col_ia     (col_ia),
        .col_shift  (col_shift),
        .col_sum    (col_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // Column: ia registered, tree sum registered, accum adds tree << shift.
    logic signed [WORDLEN-1:0] w [NROWS];
    logic [NROWS-1:0]          m_ia_q;
    logic signed [TREEW-1:0]   m_tree_q, m_tree_d;
    logic signed [SUMW-1:0]    m_tree_ext, m_accum;

    always_comb begin
        m_tree_d = '0;
        for (int i = 0; i < NROWS; i++)
            if (m_ia_q[i]) m_tree_d = m_tree_d + TREEW'(w[i]);
    end

    assign m_tree_ext = SUMW'(m_tree_q);
    assign col_sum    = m_accum;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_ia_q   <= '0;
            m_tree_q <= '0;
            m_accum  <= '0;
        end else begin
            m_ia_q   <= col_ia;
            m_tree_q <= m_tree_d;
            m_accum  <= m_accum + (m_tree_ext << col_shift);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_weights(input int w0, input int wrest);
        for (int i = 0; i < NROWS; i++) w[i] = WORDLEN'((i == 0) ? w0 : wrest);
    endtask

    task automatic fill_act(output logic [NROWS-1:0][IA_BITS-1:0] act, input int a0, input int arest);
        for (int i = 0; i < NROWS; i++) act[i] = IA_BITS'((i == 0) ? a0 : arest);
    endtask

    task automatic wait_ready(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = in_ready;
        end
        check({tag, "_in_ready"}, longint'(got), 1);
    endtask

    // Full operation with per-cycle checks of row-0 bit stream, shift alignment and latency.
    task automatic do_op(input logic [NROWS-1:0][IA_BITS-1:0] act, input longint exp_res, input string tag);
        logic [IA_BITS-1:0] a0;
        bit                 got;
        int                 c;
        longint             exp_ia, exp_sh;
        a0 = act[0];
        wait_ready(tag);
        in_act   = act;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        got = 1'b0;
        c   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1'b1;
            end else begin
                exp_ia = 0;
                if (i < IA_BITS) exp_ia = longint'(a0[i]);
                exp_sh = (i >= 2 && i < IA_BITS + 2) ? longint'(i - 2) : 0;
                check({tag, "_col_ia0"}, longint'(col_ia[0]), exp_ia);
                check({tag, "_col_shift"}, longint'(col_shift), exp_sh);
                c++;
            end
        end
        check({tag, "_latency"}, longint'(c), IA_BITS + 3);
        check({tag, "_result"}, longint'(out_result), exp_res);
        @(posedge clock);
        #1;
    endtask

    logic [NROWS-1:0][IA_BITS-1:0] act_v;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_act    = '0;
        set_weights(1, 1);
        repeat (3) @(negedge clock);
        check("rst_in_ready",   longint'(in_ready),   1);
        check("rst_out_valid",  longint'(out_valid),  0);
        check("rst_col_ia",     longint'(col_ia),     0);
        check("rst_col_shift",  longint'(col_shift),  0);
        check("rst_out_result", longint'(out_result), 0);
        check("rst_busy",       longint'(busy),       0);
        resetn = 1'b1;

        // All-ones weights, full-scale activations
        fill_act(act_v, 255, 255);
        do_op(act_v, 16320, "s1");

        // Single negative weight
        set_weights(-128, 0);
        fill_act(act_v, 255, 0);
        do_op(act_v, -32640, "s2");

        // Back-to-back; second result relies on baseline differencing
        set_weights(1, 1);
        fill_act(act_v, 255, 255);
        do_op(act_v, 16320, "s3a");
        fill_act(act_v, 3, 3);
        do_op(act_v, 192, "s3b");

        // Output backpressure with in_valid held high
        wait_ready("s4");
        out_ready = 1'b0;
        fill_act(act_v, 255, 255);
        in_act   = act_v;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        fill_act(act_v, 1, 1);
        in_act = act_v;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clock);
                got = out_valid;
            end
            check("s4_out_valid_seen", longint'(got), 1);
        end
        check("s4_result", longint'(out_result), 16320);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("s4_hold_result",    longint'(out_result), 16320);
            check("s4_hold_in_ready",  longint'(in_ready),   0);
            check("s4_hold_out_valid", longint'(out_valid),  1);
            check("s4_hold_busy",      longint'(busy),       1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        check("s4_rel_out_valid", longint'(out_valid), 0);
        check("s4_rel_in_ready",  longint'(in_ready),  1);

        // Reset during STREAM bit 3
        fill_act(act_v, 255, 255);
        in_act   = act_v;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("s5_pre_col_ia0",   longint'(col_ia[0]), 1);
        check("s5_pre_col_shift", longint'(col_shift), 1);
        resetn = 1'b0;
        #1;
        check("s5_rst_col_ia",    longint'(col_ia),    0);
        check("s5_rst_col_shift", longint'(col_shift), 0);
        check("s5_rst_out_valid", longint'(out_valid), 0);
        check("s5_rst_in_ready",  longint'(in_ready),  1);
        @(negedge clock);
        resetn = 1'b1;
        set_weights(-128, 0);
        fill_act(act_v, 255, 0);
        do_op(act_v, -32640, "s5");

        // Accumulator wrap across repeated operations
        set_weights(1, 1);
        fill_act(act_v, 255, 255);
        for (int r = 0; r < 8; r++) do_op(act_v, 16320, $sformatf("s6_%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
